// File: rtl/exec_pkg.sv
// Shared types for the execute stage: base ALU op codes, M-extension op codes
// (funct3 encoding), branch funct3 constants and the sequencing FSM states.
package exec_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_AND    = 4'd2,
        OP_OR     = 4'd3,
        OP_XOR    = 4'd4,
        OP_SLL    = 4'd5,
        OP_SRL    = 4'd6,
        OP_SRA    = 4'd7,
        OP_SLT    = 4'd8,
        OP_SLTU   = 4'd9,
        OP_PASS_B = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        M_MUL    = 3'b000,
        M_MULH   = 3'b001,
        M_MULHSU = 3'b010,
        M_MULHU  = 3'b011,
        M_DIV    = 3'b100,
        M_DIVU   = 3'b101,
        M_REM    = 3'b110,
        M_REMU   = 3'b111
    } m_op_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

endpackage

// File: rtl/exec_if.sv
// Decode-to-execute-to-writeback bus: operation in (valid/ready), result out
// (valid/ready) plus the busy indication. master = upstream/downstream side,
// slave = the execute unit.
interface exec_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic            sel_a;
    logic            sel_b;
    logic [2:0]      funct3;
    logic [4:0]      alu_ctrl;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [XLEN-1:0] imm_ext;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_result;
    logic            br_flag;
    logic            busy;

    modport master (
        output in_valid, sel_a, sel_b, funct3, alu_ctrl, pc, rdata1, rdata2, imm_ext, out_ready,
        input  in_ready, out_valid, alu_result, br_flag, busy
    );

    modport slave (
        input  in_valid, sel_a, sel_b, funct3, alu_ctrl, pc, rdata1, rdata2, imm_ext, out_ready,
        output in_ready, out_valid, alu_result, br_flag, busy
    );
endinterface

// File: rtl/exec_muldiv.sv
// Iterative RV32M datapath: shift-add multiply and restoring division on
// operand magnitudes, XLEN iterations after a one-cycle setup, then a
// combinational sign fix-up read by the parent in its FIX state.
// start loads the operands; done is high during the final iteration cycle.
module exec_muldiv
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  m_op_e           op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0]   hi_r, lo_r, dvs_r;
    logic [CW-1:0]     cnt_r;
    logic              run_r, neg_res_r, neg_rem_r;
    m_op_e             op_r;

    logic              a_neg_s, b_neg_s;
    logic [XLEN-1:0]   mag_a_s, mag_b_s;
    logic [XLEN:0]     mul_sum_s, div_shift_s, div_diff_s;
    logic [2*XLEN-1:0] prod_s;

    // Operand signedness and magnitudes for the op being started
    always_comb begin
        a_neg_s = a[XLEN-1] & (op != M_MULHU) & (op != M_DIVU) & (op != M_REMU);
        b_neg_s = b[XLEN-1] & (op != M_MULHU) & (op != M_MULHSU) & (op != M_DIVU) & (op != M_REMU);
        mag_a_s = a_neg_s ? (~a + {{(XLEN-1){1'b0}}, 1'b1}) : a;
        mag_b_s = b_neg_s ? (~b + {{(XLEN-1){1'b0}}, 1'b1}) : b;
    end

    // One iteration step for both algorithms
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, dvs_r} : {(XLEN+1){1'b0}});
        div_shift_s = {hi_r, lo_r[XLEN-1]};
        div_diff_s  = div_shift_s - {1'b0, dvs_r};
    end

    assign done = run_r & (cnt_r == CW'(XLEN-1));

    // Setup on start, then XLEN shift-add / restoring-divide iterations
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r      <= {XLEN{1'b0}};
            lo_r      <= {XLEN{1'b0}};
            dvs_r     <= {XLEN{1'b0}};
            cnt_r     <= {CW{1'b0}};
            run_r     <= 1'b0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            op_r      <= M_MUL;
        end else if (start) begin
            hi_r      <= {XLEN{1'b0}};
            lo_r      <= mag_a_s;
            dvs_r     <= mag_b_s;
            cnt_r     <= {CW{1'b0}};
            run_r     <= 1'b1;
            neg_res_r <= (a_neg_s ^ b_neg_s) & (b != {XLEN{1'b0}});
            neg_rem_r <= a_neg_s;
            op_r      <= op;
        end else if (run_r) begin
            if (op_r[2]) begin
                if (div_diff_s[XLEN]) begin
                    hi_r <= div_shift_s[XLEN-1:0];
                    lo_r <= {lo_r[XLEN-2:0], 1'b0};
                end else begin
                    hi_r <= div_diff_s[XLEN-1:0];
                    lo_r <= {lo_r[XLEN-2:0], 1'b1};
                end
            end else begin
                {hi_r, lo_r} <= {mul_sum_s, lo_r[XLEN-1:1]};
            end
            cnt_r <= cnt_r + CW'(1);
            run_r <= ~done;
        end else begin
            run_r <= 1'b0;
        end
    end

    // Sign fix-up and half / quotient / remainder selection
    always_comb begin
        prod_s = neg_res_r ? (~{hi_r, lo_r} + {{(2*XLEN-1){1'b0}}, 1'b1}) : {hi_r, lo_r};
        case (op_r)
            M_MUL:                   result = prod_s[XLEN-1:0];
            M_MULH, M_MULHSU,
            M_MULHU:                 result = prod_s[2*XLEN-1:XLEN];
            M_DIV, M_DIVU:           result = neg_res_r ? (~lo_r + {{(XLEN-1){1'b0}}, 1'b1}) : lo_r;
            M_REM, M_REMU:           result = neg_rem_r ? (~hi_r + {{(XLEN-1){1'b0}}, 1'b1}) : hi_r;
            default:                 result = {XLEN{1'b0}};
        endcase
    end
endmodule

// File: rtl/exec_unit_m.sv
// Execute stage with valid/ready handshake and registered result/branch flag.
// Optional feature macro: RV_M_EXT_EN builds the RV32M multiply/divide path
// (MUL/DIV/FIX states + exec_muldiv); without it M-ops return 0 in one cycle.
module exec_unit_m
    import exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic   clk,
    input  logic   rst_n,
    exec_if.slave  bus
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_r;
    logic            out_valid_r, br_r;
    logic [XLEN-1:0] result_r;
    logic [XLEN-1:0] src_a_s, src_b_s, base_res_s;
    logic [SHW-1:0]  shamt_s;
    logic            br_s, in_ready_s, accept_s;

    assign src_a_s    = bus.sel_a ? bus.rdata1 : bus.pc;
    assign src_b_s    = bus.sel_b ? bus.imm_ext : bus.rdata2;
    assign shamt_s    = src_b_s[SHW-1:0];
    assign in_ready_s = (state_r == ST_IDLE) & (~out_valid_r | bus.out_ready);
    assign accept_s   = bus.in_valid & in_ready_s;

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_r;
    assign bus.alu_result = result_r;
    assign bus.br_flag    = br_r;

    // Single-cycle base ALU
    always_comb begin
        case (bus.alu_ctrl[3:0])
            OP_ADD:    base_res_s = src_a_s + src_b_s;
            OP_SUB:    base_res_s = src_a_s - src_b_s;
            OP_AND:    base_res_s = src_a_s & src_b_s;
            OP_OR:     base_res_s = src_a_s | src_b_s;
            OP_XOR:    base_res_s = src_a_s ^ src_b_s;
            OP_SLL:    base_res_s = src_a_s << shamt_s;
            OP_SRL:    base_res_s = src_a_s >> shamt_s;
            OP_SRA:    base_res_s = $signed(src_a_s) >>> shamt_s;
            OP_SLT:    base_res_s = {{(XLEN-1){1'b0}}, $signed(src_a_s) < $signed(src_b_s)};
            OP_SLTU:   base_res_s = {{(XLEN-1){1'b0}}, src_a_s < src_b_s};
            OP_PASS_B: base_res_s = src_b_s;
            default:   base_res_s = ZERO;
        endcase
    end

    // Branch condition on the register operands
    always_comb begin
        case (bus.funct3)
            F3_BEQ:  br_s = (bus.rdata1 == bus.rdata2);
            F3_BNE:  br_s = (bus.rdata1 != bus.rdata2);
            F3_BLT:  br_s = ($signed(bus.rdata1) < $signed(bus.rdata2));
            F3_BGE:  br_s = ($signed(bus.rdata1) >= $signed(bus.rdata2));
            F3_BLTU: br_s = (bus.rdata1 < bus.rdata2);
            F3_BGEU: br_s = (bus.rdata1 >= bus.rdata2);
            default: br_s = 1'b0;
        endcase
    end

`ifdef RV_M_EXT_EN
    logic            div_zero_s, div_ovf_s, special_s, mdu_start_s, mdu_done_s;
    logic [XLEN-1:0] special_res_s, mdu_res_s;

    // Divide-by-zero and signed-overflow shortcuts resolved without iterating
    always_comb begin
        div_zero_s = (src_b_s == ZERO);
        div_ovf_s  = ~bus.funct3[0] & (src_a_s == SMIN) & (src_b_s == ONES);
        special_s  = bus.funct3[2] & (div_zero_s | div_ovf_s);
        case (bus.funct3)
            M_DIV:   special_res_s = div_zero_s ? ONES : src_a_s;
            M_DIVU:  special_res_s = ONES;
            M_REM:   special_res_s = div_zero_s ? src_a_s : ZERO;
            M_REMU:  special_res_s = src_a_s;
            default: special_res_s = ZERO;
        endcase
    end

    assign mdu_start_s = accept_s & bus.alu_ctrl[4] & ~special_s;
    assign bus.busy    = (state_r != ST_IDLE);

    exec_muldiv #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mdu_start_s),
        .op     (m_op_e'(bus.funct3)),
        .a      (src_a_s),
        .b      (src_b_s),
        .done   (mdu_done_s),
        .result (mdu_res_s)
    );
`else
    assign bus.busy = 1'b0;
`endif

    // Sequencing FSM and registered result / valid / branch flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            result_r    <= ZERO;
            br_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (!bus.alu_ctrl[4]) begin
                            result_r    <= base_res_s;
                            br_r        <= br_s;
                            out_valid_r <= 1'b1;
`ifdef RV_M_EXT_EN
                        end else if (special_s) begin
                            result_r    <= special_res_s;
                            br_r        <= 1'b0;
                            out_valid_r <= 1'b1;
                        end else begin
                            br_r        <= 1'b0;
                            out_valid_r <= 1'b0;
                            state_r     <= bus.funct3[2] ? ST_DIV : ST_MUL;
`else
                        end else begin
                            result_r    <= ZERO;
                            br_r        <= 1'b0;
                            out_valid_r <= 1'b1;
`endif
                        end
                    end else if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                    end else begin
                        out_valid_r <= out_valid_r;
                    end
                end
`ifdef RV_M_EXT_EN
                ST_MUL, ST_DIV: begin
                    if (mdu_done_s) begin
                        state_r <= ST_FIX;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_FIX: begin
                    result_r    <= mdu_res_s;
                    br_r        <= 1'b0;
                    out_valid_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
`endif
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_exec_unit_m.sv
// Self-checking bench for exec_unit_m (XLEN = 32): directed test-plan cases,
// backpressure, throughput, mid-operation reset and randomized operations,
// all checked against an arithmetic reference model. Follows RV_M_EXT_EN.
module tb_exec_unit_m;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    exec_if #(.XLEN(32)) bus ();
    exec_unit_m #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference result from the operation's arithmetic definition
    function automatic logic [31:0] ref_result(input logic [4:0] ctrl, input logic [2:0] f3,
                                               input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        longint p;
        logic [63:0] u;
        sa = a;
        sb = b;
        if (ctrl[4]) begin
`ifdef RV_M_EXT_EN
            case (f3)
                3'd0: begin p = longint'(sa) * longint'(sb); return p[31:0]; end
                3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
                3'd2: begin p = longint'(sa) * longint'(b); return p[63:32]; end
                3'd3: begin u = {32'd0, a} * {32'd0, b}; return u[63:32]; end
                3'd4: begin
                    if (b == 32'd0) return 32'hFFFF_FFFF;
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                    return sa / sb;
                end
                3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
                3'd6: begin
                    if (b == 32'd0) return a;
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                    return sa % sb;
                end
                default: return (b == 32'd0) ? a : a % b;
            endcase
`else
            return 32'd0;
`endif
        end
        case (ctrl[3:0])
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << b[4:0];
            4'd6:  return a >> b[4:0];
            4'd7:  return $signed(a) >>> b[4:0];
            4'd8:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_branch(input logic [4:0] ctrl, input logic [2:0] f3,
                                        input logic [31:0] r1, input logic [31:0] r2);
        int s1, s2;
        s1 = r1;
        s2 = r2;
        if (ctrl[4]) return 1'b0;
        case (f3)
            3'b000: return r1 == r2;
            3'b001: return r1 != r2;
            3'b100: return s1 < s2;
            3'b101: return s1 >= s2;
            3'b110: return r1 < r2;
            3'b111: return r1 >= r2;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [4:0] ctrl, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] b);
`ifdef RV_M_EXT_EN
        if (!ctrl[4]) return 1;
        if (f3[2] && (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return 34;
`else
        return 1;
`endif
    endfunction

    task automatic drive(input logic [4:0] ctrl, input logic [2:0] f3, input logic sa, input logic sb,
                         input logic [31:0] pcv, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] imm);
        bus.alu_ctrl = ctrl; bus.funct3 = f3; bus.sel_a = sa; bus.sel_b = sb;
        bus.pc = pcv; bus.rdata1 = r1; bus.rdata2 = r2; bus.imm_ext = imm;
    endtask

    // Issue one op with out_ready held high and check result, flag and latency
    task automatic run_op(input string tag, input logic [4:0] ctrl, input logic [2:0] f3,
                          input logic sa, input logic sb, input logic [31:0] pcv,
                          input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm);
        logic [31:0] a, b;
        int exp_lat, lat, w, busy_low;
        a = sa ? r1 : pcv;
        b = sb ? imm : r2;
        exp_lat = ref_latency(ctrl, f3, a, b);
        @(negedge clk);
        drive(ctrl, f3, sa, sb, pcv, r1, r2, imm);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 100) begin @(negedge clk); w++; end
        if (w >= 100) check_eq({tag, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        busy_low = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!bus.out_valid && !bus.busy) busy_low++;
        end while (!bus.out_valid && lat < 100);
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_res"}, bus.alu_result, ref_result(ctrl, f3, a, b));
        check_eq({tag, "_br"}, {31'd0, bus.br_flag}, {31'd0, ref_branch(ctrl, f3, r1, r2)});
        if (exp_lat > 1) check_eq({tag, "_busy_gap"}, busy_low, 32'd0);
        check_eq({tag, "_busy_end"}, {31'd0, bus.busy}, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return $urandom_range(0, 40);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] held;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drive(5'd0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("rst_result", bus.alu_result, 32'd0);
        check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Directed test-plan cases
        run_op("add", 5'd0, 3'd0, 1'b1, 1'b1, 32'd0, 32'd5, 32'd0, 32'hFFFF_FFFD);
        run_op("pc_add", 5'd0, 3'd0, 1'b0, 1'b1, 32'h100, 32'd5, 32'd0, 32'd4);
        run_op("mulh", 5'd16, 3'd1, 1'b1, 1'b0, 32'd0, 32'hFFFF_FFFE, 32'd3, 32'd0);
        run_op("mulhu", 5'd16, 3'd3, 1'b1, 1'b0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        run_op("div", 5'd16, 3'd4, 1'b1, 1'b0, 32'd0, 32'hFFFF_FFF9, 32'd2, 32'd0);
        run_op("rem", 5'd16, 3'd6, 1'b1, 1'b0, 32'd0, 32'hFFFF_FFF9, 32'd2, 32'd0);
        run_op("divu0", 5'd16, 3'd5, 1'b1, 1'b0, 32'd0, 32'd7, 32'd0, 32'd0);
        run_op("divovf", 5'd16, 3'd4, 1'b1, 1'b0, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_op("bltu", 5'd0, 3'b110, 1'b1, 1'b0, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'd0);
        run_op("blt", 5'd0, 3'b100, 1'b1, 1'b0, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'd0);
        run_op("br_undef", 5'd0, 3'b010, 1'b1, 1'b0, 32'd0, 32'd3, 32'd3, 32'd0);

        // Back-to-back SUB then SRA: one result per cycle
        @(negedge clk);
        drive(5'd1, 3'd0, 1'b1, 1'b0, 32'd0, 32'd10, 32'd30, 32'd0);
        bus.in_valid = 1'b1;
        @(negedge clk);
        check_eq("b2b_sub_valid", {31'd0, bus.out_valid}, 32'd1);
        check_eq("b2b_sub_res", bus.alu_result, 32'hFFFF_FFEC);
        drive(5'd7, 3'd0, 1'b1, 1'b1, 32'd0, 32'h8000_0010, 32'd0, 32'd4);
        @(negedge clk);
        check_eq("b2b_sra_valid", {31'd0, bus.out_valid}, 32'd1);
        check_eq("b2b_sra_res", bus.alu_result, 32'hF800_0001);
        bus.in_valid = 1'b0;

        // Backpressure: result held, no accept, then consume+accept together
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(5'd0, 3'd0, 1'b1, 1'b0, 32'd0, 32'd100, 32'd23, 32'd0);
        bus.in_valid = 1'b1;
        @(negedge clk);
        held = bus.alu_result;
        check_eq("bp_first", held, 32'd123);
        drive(5'd4, 3'd0, 1'b1, 1'b0, 32'd0, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'd0);
        check_eq("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        repeat (3) @(negedge clk);
        check_eq("bp_stable", bus.alu_result, 32'd123);
        check_eq("bp_valid_held", {31'd0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b1;
        #1 check_eq("bp_ready_comb", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        check_eq("bp_new_valid", {31'd0, bus.out_valid}, 32'd1);
        check_eq("bp_new_res", bus.alu_result, 32'h0F0F_F0F0);
        bus.in_valid = 1'b0;
        @(negedge clk);

        // Reset in the middle of a DIV aborts it
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(5'd16, 3'd4, 1'b1, 1'b0, 32'd0, 32'hFFFF_FF9C, 32'd7, 32'd0);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
`ifdef RV_M_EXT_EN
        check_eq("mid_div_busy", {31'd0, bus.busy}, 32'd1);
`endif
        rst_n = 1'b0;
        #1;
        check_eq("abort_valid", {31'd0, bus.out_valid}, 32'd0);
        check_eq("abort_result", bus.alu_result, 32'd0);
        check_eq("abort_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("abort_br", {31'd0, bus.br_flag}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_eq("abort_no_result", {31'd0, bus.out_valid}, 32'd0);
        run_op("post_rst_add", 5'd0, 3'd0, 1'b1, 1'b1, 32'd0, 32'd5, 32'd0, 32'hFFFF_FFFD);

        // Randomized operations against the reference model
        for (int i = 0; i < 150; i++) begin
            int v;
            logic [4:0] ctrl;
            logic [2:0] f3;
            v = $urandom_range(0, 23);
            f3 = 3'($urandom_range(0, 7));
            if (v < 16) ctrl = 5'(v);
            else begin ctrl = 5'd16; f3 = 3'(v - 16); end
            run_op($sformatf("rnd%0d_op%0d_f%0d", i, ctrl, f3), ctrl, f3,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   pick(), pick(), pick(), pick());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/exec_unit_m.md
# exec_unit_m

Parametrised execute stage with a valid/ready handshake and a registered result. It selects the operands (PC or rs1 for A, rs2 or immediate for B) and resolves the branch condition. Base ALU operations complete in one cycle. RV32M multiply/divide operations run on an iterative, multi-cycle datapath. The block sits between decode and memory/writeback and replaces the purely combinational execute stage, so the pipeline can stall on long operations.

## Interface
- XLEN, 32, datapath width; must be a power of two and ≥ 8.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  the operation on the input bus is valid.
- in_ready  out  1  the block accepts an operation this cycle.
- sel_a  in  1  0: SrcA = pc; 1: SrcA = rdata1.
- sel_b  in  1  0: SrcB = rdata2; 1: SrcB = imm_ext.
- funct3  in  3  branch condition (BEQ/BNE/BLT/BGE/BLTU/BGEU encodings); also selects the M-op when alu_ctrl[4] = 1.
- alu_ctrl  in  5  alu_ctrl[4] = 0: base op from alu_ctrl[3:0]; alu_ctrl[4] = 1: M-extension op selected by funct3.
- pc, rdata1, rdata2, imm_ext  in  XLEN each  operand sources.
- out_valid  out  1  the result registers hold a valid result.
- out_ready  in  1  downstream consumes the result.
- alu_result  out  XLEN  registered result.
- br_flag  out  1  registered branch condition; computed from rdata1/rdata2 only.
- busy  out  1  an iterative M-op is in progress.

## Operation
- Transfer in: in_valid & in_ready. in_ready = (state == IDLE) & (!out_valid | out_ready). This is a combinational path from out_ready.
- Transfer out: out_valid & out_ready. The result holds stable while out_valid & !out_ready.
- Base ops, alu_ctrl[3:0]:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; the shift amount is SrcB[log2(XLEN)-1:0].
  - 8 SLT, 9 SLTU.
  - 10 PASS_B.
  - 11–15 produce 0.
  - All results are modulo 2^XLEN.
- br_flag: eq/ne/lt/ge/ltu/geu on rdata1 vs rdata2. Undefined funct3 values (010, 011) give 0. br_flag is forced to 0 for M-ops.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE: a base op is accepted and the output registers load on the next edge. A MUL/MULH/MULHSU/MULHU op moves to MUL. A DIV/DIVU/REM/REMU op moves to DIV unless it is a special case.
  - MUL: shift-add on operand magnitudes for XLEN cycles, producing a 2·XLEN product. Then go to FIX.
  - DIV: restoring radix-2 division on magnitudes for XLEN cycles. Then go to FIX.
  - FIX: apply the sign corrections, select the low or high half (or quotient/remainder), load the output registers, set out_valid, and return to IDLE.
- Signedness: MUL and MULH are signed × signed; MULHSU is signed × unsigned; MULHU is unsigned. For division:
  - The quotient is negative iff the operand signs differ and the divisor ≠ 0.
  - The remainder takes the dividend's sign.
- Special cases are resolved in IDLE with base-op latency and never enter DIV:
  - Divisor 0: quotient = all-ones; remainder = dividend.
  - Signed overflow (−2^(XLEN−1) / −1): quotient = dividend; remainder = 0.
- M-ops take SrcA/SrcB exactly as base ops do.
- busy = (state ∈ {MUL, DIV, FIX}).

## Timing
- Reset values: out_valid 0, alu_result 0, br_flag 0, busy 0, state IDLE, all iteration registers 0. in_ready is 1 once rst_n deasserts.
- Reset asserted mid-operation aborts immediately. No result is produced and the aborted op is not replayed.
- Latency, accept edge to out_valid:
  - Base op and divide special cases: 1 cycle.
  - MUL/DIV: XLEN + 2 cycles (1 setup + XLEN iterations + FIX).
- Throughput: one base op per cycle when out_ready is held at 1.
- No new op is accepted while busy, or while out_valid & !out_ready.
- When a result is consumed and a new op is accepted in the same cycle, out_valid stays 1 with the new result.

## Configuration
- RV_M_EXT_EN defined: M-ops, the MUL/DIV/FIX states and the exec_muldiv datapath are built as described above.
- RV_M_EXT_EN undefined:
  - alu_ctrl[4] = 1 ops complete in 1 cycle with alu_result = 0 and br_flag = 0.
  - busy is tied to 0.
  - The FSM reduces to IDLE.

## Structure
- Package exec_pkg holds:
  - the alu_op_e enum (4-bit base op codes);
  - the m_op_e enum (MUL = 000 … REMU = 111, the funct3 encoding);
  - the branch funct3 constants;
  - the state_e FSM enum.
- Sub-module exec_muldiv holds the iteration registers, counter and sign fix-up. It is compiled only under RV_M_EXT_EN. Its handshake is start/done. Operand muxes, the base ALU and br_flag stay in exec_unit_m.

## Test plan
- ADD: rdata1 = 5, imm_ext = −3, sel_a = 1, sel_b = 1 → alu_result 2, out_valid one cycle after accept. Back-to-back SUB/SRA ops with out_ready = 1 → one result per cycle.
- Backpressure: out_ready = 0 with a result pending → in_ready 0 and alu_result stable. Raise out_ready → consume and accept a new op in the same cycle.
- MULH: −2 × 3 at XLEN = 32 → 0xFFFF_FFFF after 34 cycles, busy high throughout.
- MULHU: 0xFFFF_FFFF² → 0xFFFF_FFFE.
- DIV −7/2 → −3; REM −7/2 → −1; DIVU 7/0 → 0xFFFF_FFFF at 1-cycle latency; DIV 0x8000_0000/−1 → 0x8000_0000.
- BLTU: rdata1 = 1, rdata2 = 0xFFFF_FFFF → br_flag 1. BLT on the same operands → br_flag 0.
- Reset: assert rst_n = 0 on cycle 10 of a DIV → all outputs reset. After release, a new ADD completes normally.
